stopwatch_controller: RTL

// Control core of the stopwatch: conditions the pause/reset buttons and the sel/adj switches, runs the
// RUN/PAUSE/ADJUST state machine and owns the MM:SS BCD time registers. Its four BCD digits feed the

---
 rtl/stopwatch_controller_pkg.sv | 22 ++
 rtl/stopwatch_controller_button_debouncer.sv | 62 ++++++
 rtl/stopwatch_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_controller_pkg.sv
// Shared definitions for the stopwatch control core.
// Contents:
//   state_e       - RUN / PAUSE / ADJUST state encoding (2-bit)
//   SEC_TENS_MAX  - largest tens-of-seconds digit (5)
//   DIGIT_MAX     - largest BCD digit (9)
//   bcd_inc       - single-digit BCD increment that wraps to 0 above a given limit
package stopwatch_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] digit, input logic [3:0] max);
    return (digit >= max) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_controller_button_debouncer.sv
// Button conditioner: 2-flop synchronizer, level debouncer and rising-edge pulse.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   btn_raw  in   raw asynchronous button level, active-high
//   pulse    out  1-cycle pulse when the debounced level rises
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        // pulse coincides with the cycle the accepted level first shows high
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control core: button/switch conditioning, RUN/PAUSE/ADJUST FSM and
// the MM:SS BCD time registers.
// Ports:
//   clk, rst_n               system clock, synchronous active-low reset
//   tick_1hz                 1-cycle enable, advances time in RUN
//   tick_adj                 1-cycle enable, advances selected field in ADJUST
//   btn_pause, btn_reset     raw async buttons, active-high
//   sw_sel, sw_adj           raw async switches (sel: 0 minutes / 1 seconds)
//   minutes_tens..seconds_ones  BCD time digits
//   adj, sel                 synchronized, registered switch levels
//   running                  high while in RUN
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_PAUSE  | time frozen, waiting for pause button (reset state)
// ST_RUN    | seconds advance on tick_1hz
// ST_ADJUST | selected field advances on tick_adj, no carry between fields
module stopwatch_controller
  import stopwatch_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_sel,
  input  logic       sw_adj,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_ones,
  output logic [3:0] seconds_tens,
  output logic [3:0] seconds_ones,
  output logic       adj,
  output logic       sel,
  output logic       running
);

  logic pause_p, reset_p;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_pause (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_pause), .pulse(pause_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_reset (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_reset), .pulse(reset_p)
  );

  logic adj_s1_q, adj_s1_d, adj_s2_q, adj_s2_d, adj_q, adj_d;
  logic sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_q, sel_d;

  always_comb begin
    adj_s1_d = sw_adj;
    adj_s2_d = adj_s1_q;
    adj_d    = adj_s2_q;
    sel_s1_d = sw_sel;
    sel_s2_d = sel_s1_q;
    sel_d    = sel_s2_q;
  end

  state_e     state_q, state_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;

  always_comb begin
    state_d = state_q;
    if (adj_q) begin
      state_d = ST_ADJUST;
    end else begin
      unique case (state_q)
        ST_ADJUST: state_d = ST_PAUSE;
        ST_PAUSE:  if (pause_p) state_d = ST_RUN;
        ST_RUN:    if (pause_p || reset_p) state_d = ST_PAUSE;
        default:   state_d = ST_PAUSE;
      endcase
    end
  end

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (reset_p) begin
      mt_d = 4'd0;
      mo_d = 4'd0;
      st_d = 4'd0;
      so_d = 4'd0;
    end else if (state_q == ST_RUN && tick_1hz) begin
      // full ripple carry; 99:59 rolls over to 00:00
      so_d = bcd_inc(so_q, DIGIT_MAX);
      if (so_q == DIGIT_MAX) begin
        st_d = bcd_inc(st_q, SEC_TENS_MAX);
        if (st_q == SEC_TENS_MAX) begin
          mo_d = bcd_inc(mo_q, DIGIT_MAX);
          if (mo_q == DIGIT_MAX) mt_d = bcd_inc(mt_q, DIGIT_MAX);
        end
      end
    end else if (state_q == ST_ADJUST && tick_adj) begin
      // each field wraps on its own; seconds never carry into minutes here
      if (sel_q) begin
        so_d = bcd_inc(so_q, DIGIT_MAX);
        if (so_q == DIGIT_MAX) st_d = bcd_inc(st_q, SEC_TENS_MAX);
      end else begin
        mo_d = bcd_inc(mo_q, DIGIT_MAX);
        if (mo_q == DIGIT_MAX) mt_d = bcd_inc(mt_q, DIGIT_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adj_s1_q <= 1'b0;
      adj_s2_q <= 1'b0;
      adj_q    <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
      sel_q    <= 1'b0;
      state_q  <= ST_PAUSE;
      mt_q     <= 4'd0;
      mo_q     <= 4'd0;
      st_q     <= 4'd0;
      so_q     <= 4'd0;
    end else begin
      adj_s1_q <= adj_s1_d;
      adj_s2_q <= adj_s2_d;
      adj_q    <= adj_d;
      sel_s1_q <= sel_s1_d;
      sel_s2_q <= sel_s2_d;
      sel_q    <= sel_d;
      state_q  <= state_d;
      mt_q     <= mt_d;
      mo_q     <= mo_d;
      st_q     <= st_d;
      so_q     <= so_d;
    end
  end

  assign minutes_tens = mt_q;
  assign minutes_ones = mo_q;
  assign seconds_tens = st_q;
  assign seconds_ones = so_q;
  assign adj          = adj_q;
  assign sel          = sel_q;
  assign running      = (state_q == ST_RUN);

endmodule
